// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, counter/coordinate types and a window-decode helper.
// Also used by the sprite renderers.
package vga_pkg;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;

  localparam int unsigned H_TOTAL = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int unsigned V_TOTAL = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef logic [9:0]  coord_t;
  // Counters are one bit wider than coordinates so totals up to 2047 never wrap early.
  typedef logic [10:0] cnt_t;

  function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// Parameterised-depth shift register for active-low sync lines; resets to the
// inactive level so a reset never leaves a partial sync pulse behind.
module sync_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic w_unused_bypass;
      assign w_unused_bypass = i_clk ^ i_rst_n;
      assign o_q = i_d;
    end else if (DEPTH == 1) begin : g_one
      logic r_q;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_q <= 1'b1;
        else          r_q <= i_d;
      end
      assign o_q = r_q;
    end else begin : g_chain
      logic [DEPTH-1:0] r_sr;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sr <= '1;
        else          r_sr <= {r_sr[DEPTH-2:0], i_d};
      end
      assign o_q = r_sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel/line counters, delayed active-low syncs, frame-start
// pulse and a tempo-driven beat tick that fires every tempo_frames frames.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF,
  parameter int unsigned SYNC_DLY  = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [7:0] tempo_frames,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       beat_tick
);

  localparam cnt_t C_H_TOTAL   = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam cnt_t C_V_TOTAL   = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam cnt_t C_H_VIS     = cnt_t'(H_VISIBLE);
  localparam cnt_t C_V_VIS     = cnt_t'(V_VISIBLE);
  localparam cnt_t C_H_SYNC_LO = cnt_t'(H_VISIBLE + H_FRONT);
  localparam cnt_t C_H_SYNC_HI = cnt_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam cnt_t C_V_SYNC_LO = cnt_t'(V_VISIBLE + V_FRONT);
  localparam cnt_t C_V_SYNC_HI = cnt_t'(V_VISIBLE + V_FRONT + V_SYNC);

  cnt_t       r_h_cnt;
  cnt_t       r_v_cnt;
  logic [7:0] r_frame_cnt;

  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_hs_n;
  logic       w_vs_n;
  logic       w_frame_start;
  logic       w_beat;
  logic [7:0] w_tempo_eff;

  always_comb begin
    w_h_wrap    = (r_h_cnt == C_H_TOTAL - 11'd1);
    w_v_wrap    = (r_v_cnt == C_V_TOTAL - 11'd1);
    w_hs_n      = !in_window(r_h_cnt, C_H_SYNC_LO, C_H_SYNC_HI);
    w_vs_n      = !in_window(r_v_cnt, C_V_SYNC_LO, C_V_SYNC_HI);
    // Gated by reset_n so the pulse is low during reset yet present in the
    // very first cycle after release, when the counters already read 0,0.
    w_frame_start = reset_n && (r_h_cnt == '0) && (r_v_cnt == '0);
    w_tempo_eff   = (tempo_frames == 8'd0) ? 8'd1 : tempo_frames;
    // >= (not ==) so a tempo lowered below the running count still ticks next frame.
    w_beat        = w_frame_start && (r_frame_cnt >= w_tempo_eff - 8'd1);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (w_h_wrap) begin
      r_h_cnt <= '0;
      r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n)           r_frame_cnt <= '0;
    else if (w_frame_start) r_frame_cnt <= w_beat ? 8'd0 : r_frame_cnt + 8'd1;
  end

  sync_delay #(.DEPTH(SYNC_DLY)) u_hs_dly (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     (w_hs_n),
    .o_q     (hs)
  );

  sync_delay #(.DEPTH(SYNC_DLY)) u_vs_dly (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_d     (w_vs_n),
    .o_q     (vs)
  );

  assign DrawX       = r_h_cnt[9:0];
  assign DrawY       = r_v_cnt[9:0];
  assign blank       = (r_h_cnt < C_H_VIS) && (r_v_cnt < C_V_VIS);
  assign frame_start = w_frame_start;
  assign beat_tick   = w_beat;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three full-size instances (sync delay 0/1/2) and one
// reduced-geometry instance for frame-level behaviour, against a closed-form raster model.
module tb_vga_timing_gen;

  localparam int SH_VIS = 16, SH_FP = 2, SH_SY = 4, SH_BP = 3;
  localparam int SV_VIS = 8,  SV_FP = 2, SV_SY = 2, SV_BP = 3;
  localparam int SFRAME = (SH_VIS + SH_FP + SH_SY + SH_BP) * (SV_VIS + SV_FP + SV_SY + SV_BP);

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst_n, rst_sm_n;
  logic [7:0] tempo_big, tempo_sm;

  logic [9:0] x0, y0, x1, y1, x2, y2, xs, ys;
  logic bl0, hs0, vs0, fs0, bt0;
  logic bl1, hs1, vs1, fs1, bt1;
  logic bl2, hs2, vs2, fs2, bt2;
  logic bls, hss, vss, fss, bts;

  vga_timing_gen #(.SYNC_DLY(0)) u_d0 (
    .vga_clk(clk), .reset_n(rst_n), .tempo_frames(tempo_big),
    .DrawX(x0), .DrawY(y0), .blank(bl0), .hs(hs0), .vs(vs0),
    .frame_start(fs0), .beat_tick(bt0));

  vga_timing_gen u_d1 (
    .vga_clk(clk), .reset_n(rst_n), .tempo_frames(tempo_big),
    .DrawX(x1), .DrawY(y1), .blank(bl1), .hs(hs1), .vs(vs1),
    .frame_start(fs1), .beat_tick(bt1));

  vga_timing_gen #(.SYNC_DLY(2)) u_d2 (
    .vga_clk(clk), .reset_n(rst_n), .tempo_frames(tempo_big),
    .DrawX(x2), .DrawY(y2), .blank(bl2), .hs(hs2), .vs(vs2),
    .frame_start(fs2), .beat_tick(bt2));

  vga_timing_gen #(
    .H_VISIBLE(SH_VIS), .H_FRONT(SH_FP), .H_SYNC(SH_SY), .H_BACK(SH_BP),
    .V_VISIBLE(SV_VIS), .V_FRONT(SV_FP), .V_SYNC(SV_SY), .V_BACK(SV_BP),
    .SYNC_DLY(1)
  ) u_sm (
    .vga_clk(clk), .reset_n(rst_sm_n), .tempo_frames(tempo_sm),
    .DrawX(xs), .DrawY(ys), .blank(bls), .hs(hss), .vs(vss),
    .frame_start(fss), .beat_tick(bts));

  int checks = 0;
  int errors = 0;
  int t_big, t_sm, bm;
  logic big_run, sm_run;

  int mm_cnt = 0, mm_who, mm_t;
  logic [24:0] mm_obs, mm_exp;

  // Closed-form raster position after t cycles since release: {x, y, blank, hs, vs, frame_start}.
  function automatic logic [23:0] model(int t, int dly, int hv, int hf, int hsz, int hb,
                                        int vv, int vf, int vsz, int vb);
    int ht, vt, x, y, p, px, py;
    logic hs_e, vs_e;
    ht = hv + hf + hsz + hb;
    vt = vv + vf + vsz + vb;
    x  = t % ht;
    y  = (t / ht) % vt;
    if (t < dly) begin
      hs_e = 1'b1;
      vs_e = 1'b1;
    end else begin
      p    = t - dly;
      px   = p % ht;
      py   = (p / ht) % vt;
      hs_e = !(px >= hv + hf && px < hv + hf + hsz);
      vs_e = !(py >= vv + vf && py < vv + vf + vsz);
    end
    return {10'(x), 10'(y), (x < hv) && (y < vv), hs_e, vs_e, (x == 0) && (y == 0)};
  endfunction

  task automatic note(int who, int t, logic [24:0] obs, logic [24:0] exp);
    if (obs !== exp) begin
      if (mm_cnt == 0) begin
        mm_who = who; mm_t = t; mm_obs = obs; mm_exp = exp;
      end
      mm_cnt++;
    end
  endtask

  task automatic check_big();
    logic [23:0] e;
    e = model(t_big, 0, 640, 16, 96, 48, 480, 10, 2, 33);
    note(0, t_big, {x0, y0, bl0, hs0, vs0, fs0, bt0}, {e, e[0]});
    e = model(t_big, 1, 640, 16, 96, 48, 480, 10, 2, 33);
    note(1, t_big, {x1, y1, bl1, hs1, vs1, fs1, bt1}, {e, e[0]});
    e = model(t_big, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    note(2, t_big, {x2, y2, bl2, hs2, vs2, fs2, bt2}, {e, e[0]});
  endtask

  // bm = frames seen since the last beat; a beat is due once bm+1 reaches the tempo.
  task automatic check_sm();
    logic [23:0] e;
    logic eb;
    int eff;
    eff = (tempo_sm == 8'd0) ? 1 : int'(tempo_sm);
    e   = model(t_sm, 1, SH_VIS, SH_FP, SH_SY, SH_BP, SV_VIS, SV_FP, SV_SY, SV_BP);
    eb  = e[0] && (bm + 1 >= eff);
    note(3, t_sm, {xs, ys, bls, hss, vss, fss, bts}, {e, eb});
    if (e[0]) bm = eb ? 0 : bm + 1;
  endtask

  task automatic step();
    @(posedge clk);
    if (big_run) t_big++;
    if (sm_run)  t_sm++;
    @(negedge clk);
    if (big_run) check_big();
    if (sm_run)  check_sm();
  endtask

  task automatic chk(string tag, int obs, int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic report_mm(string tag);
    checks++;
    assert (mm_cnt === 0) else begin
      errors++;
      $error("FAIL %s mismatches=%0d inst=%0d t=%0d observed=%h expected=%h",
             tag, mm_cnt, mm_who, mm_t, mm_obs, mm_exp);
    end
    mm_cnt = 0;
  endtask

  task automatic reset_sm();
    rst_sm_n = 1'b0;
    sm_run   = 1'b0;
    #1;
    chk("sm_async_reset", int'({xs, ys, hss, vss, fss, bts}), 24'h00000C);
    step();
    step();
    rst_sm_n = 1'b1;
    #1;
    t_sm   = 0;
    bm     = 0;
    sm_run = 1'b1;
    check_sm();
  endtask

  task automatic run_sm(int n, output int fs_n, output int vs_lo, output int bl_hi,
                        output int mask, output int stray);
    fs_n = 0; vs_lo = 0; bl_hi = 0; mask = 0; stray = 0;
    for (int i = 0; i < n; i++) begin
      if (fss) begin
        if (bts) mask |= (1 << fs_n);
        fs_n++;
      end
      if (bts && !fss) stray++;
      if (!vss) vs_lo++;
      if (bls) bl_hi++;
      step();
    end
  endtask

  initial begin
    int f0, f1, f2, n0, n1, n2;
    int fs_n, vs_lo, bl_hi, mask, stray;

    rst_n = 1'b0; rst_sm_n = 1'b0;
    tempo_big = 8'd0; tempo_sm = 8'd4;
    big_run = 1'b0; sm_run = 1'b0;
    t_big = 0; t_sm = 0; bm = 0;
    repeat (3) @(negedge clk);
    chk("reset_d1", int'({x1, y1, hs1, vs1, fs1, bt1}), 24'h00000C);
    chk("reset_sm", int'({xs, ys, hss, vss, fss, bts}), 24'h00000C);

    rst_n = 1'b1; rst_sm_n = 1'b1;
    #1;
    big_run = 1'b1; sm_run = 1'b1;
    chk("release_fs_d1", int'({x1, y1, fs1}), 21'h000001);
    check_big();
    check_sm();

    // One full line on the full-size instances.
    f0 = -1; f1 = -1; f2 = -1; n0 = 0; n1 = 0; n2 = 0;
    for (int i = 0; i < 800; i++) begin
      if (!hs0) begin n0++; if (f0 < 0) f0 = int'(x0); end
      if (!hs1) begin n1++; if (f1 < 0) f1 = int'(x1); end
      if (!hs2) begin n2++; if (f2 < 0) f2 = int'(x2); end
      step();
    end
    chk("line_wrap_x", int'(x1), 0);
    chk("line_wrap_y", int'(y1), 1);
    chk("hs_len_dly1", n1, 96);
    chk("hs_fall_dly1", f1, 657);
    chk("hs_len_dly0", n0, 96);
    chk("hs_fall_dly0", f0, 656);
    chk("hs_fall_dly2", f2, 658);
    chk("hs_len_dly2", n2, 96);
    report_mm("model_line");

    // Whole reduced frame.
    reset_sm();
    run_sm(SFRAME, fs_n, vs_lo, bl_hi, mask, stray);
    chk("frame_fs_count", fs_n, 1);
    chk("frame_vs_low", vs_lo, SV_SY * (SH_VIS + SH_FP + SH_SY + SH_BP));
    chk("frame_blank_high", bl_hi, SH_VIS * SV_VIS);
    report_mm("model_frame");

    // Random tempo changes at random points.
    for (int k = 0; k < 6; k++) begin
      tempo_sm = 8'($urandom_range(0, 5));
      run_sm($urandom_range(100, 800), fs_n, vs_lo, bl_hi, mask, stray);
      chk("rand_stray_beat", stray, 0);
    end
    report_mm("model_random");

    tempo_sm = 8'd4;
    reset_sm();
    run_sm(12 * SFRAME, fs_n, vs_lo, bl_hi, mask, stray);
    chk("tempo4_fs_count", fs_n, 12);
    chk("tempo4_beat_frames", mask, 32'h888);
    chk("tempo4_stray_beat", stray, 0);
    report_mm("model_tempo4");

    tempo_sm = 8'd0;
    reset_sm();
    run_sm(5 * SFRAME, fs_n, vs_lo, bl_hi, mask, stray);
    chk("tempo0_beat_frames", mask, 32'h1F);
    report_mm("model_tempo0");

    tempo_sm = 8'd10;
    reset_sm();
    run_sm(5 * SFRAME - 1, fs_n, vs_lo, bl_hi, mask, stray);
    chk("tempo10_no_beat", mask, 0);
    chk("tempo10_fs_count", fs_n, 5);
    tempo_sm = 8'd2;
    run_sm(1 + 3 * SFRAME, fs_n, vs_lo, bl_hi, mask, stray);
    chk("tempo_drop_beats", mask, 32'h5);
    report_mm("model_tempo_drop");

    // Mid-frame asynchronous reset inside both sync pulses.
    tempo_sm = 8'd4;
    reset_sm();
    repeat (270) step();
    #5;
    chk("pre_reset_pos", int'({xs, ys}), (20 << 10) | 10);
    chk("pre_reset_syncs", int'({hss, vss}), 0);
    rst_sm_n = 1'b0;
    sm_run   = 1'b0;
    #1;
    chk("midframe_async_reset", int'({xs, ys, hss, vss, fss, bts}), 24'h00000C);
    step();
    rst_sm_n = 1'b1;
    #1;
    chk("post_reset_first", int'({xs, ys, fss}), 21'h000001);
    t_sm = 0; bm = 0; sm_run = 1'b1;
    check_sm();
    repeat (400) step();
    report_mm("model_post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter SYNC_DLY, default 1, cycles of delay on hs/vs to match the downstream renderer's registered colour.
REQ-006 SHALL have port vga_clk, input, 1, pixel clock (25 MHz).
REQ-007 SHALL have port reset_n, input, 1, reset; the block uses one clock, and reset is asynchronous and active-low.
REQ-008 SHALL have port tempo_frames, input, 8, frames per beat tick; sampled only at frame start.
REQ-009 SHALL have port DrawX, output, 10, current pixel column.
REQ-010 SHALL have port DrawY, output, 10, current pixel row.
REQ-011 SHALL have port blank, output, 1, display-enable: high when DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-012 SHALL have port hs and vs, outputs, 1 each, active-low sync, delayed SYNC_DLY cycles.
REQ-013 SHALL have port frame_start, output, 1, one-cycle pulse at DrawX=0, DrawY=0.
REQ-014 SHALL have port beat_tick, output, 1, one-cycle pulse coincident with frame_start every tempo_frames frames.

Function
REQ-015 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800), wrapping to 0 every cycle after H_TOTAL-1.
REQ-016 SHALL increment v_cnt only on the h_cnt wrap, counting 0..V_TOTAL-1 (525) and wrapping to 0.
REQ-017 SHALL drive DrawX=h_cnt and DrawY=v_cnt registered, with blank combinationally decoded from the same registers (zero relative skew).
REQ-018 SHALL assert the undelayed hsync when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-019 SHALL assert the undelayed vsync when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (490..491), for whole lines.
REQ-020 SHALL pass hs/vs through a SYNC_DLY-stage shift register; SYNC_DLY=0 SHALL mean no delay.
REQ-021 SHALL assert frame_start for exactly the cycle where h_cnt=0 and v_cnt=0.
REQ-022 SHALL hold an 8-bit frame counter, incremented on frame_start, generating beat_tick when it reaches tempo_frames-1 on a frame_start, then clearing it.
REQ-023 SHALL treat tempo_frames=0 as 1 (beat_tick on every frame_start).
REQ-024 SHALL, if tempo_frames drops below the current count mid-count, fire beat_tick at the next frame_start and clear.
REQ-025 SHALL widen all comparisons to 11 bits so that H_TOTAL up to 2047 does not overflow.

Reset
REQ-026 SHALL, on reset_n low, immediately clear h_cnt, v_cnt, frame counter and the sync delay line; DrawX=0, DrawY=0, hs=1, vs=1, frame_start=0, beat_tick=0.
REQ-027 SHALL, on reset release, produce frame_start on the first rising edge at which reset_n is sampled high, with counting starting from 0,0.
REQ-028 SHALL, on reset mid-frame, abandon the frame with no partial sync pulse held low.

Structure
REQ-029 SHALL place the timing defaults, H_TOTAL/V_TOTAL and the 10-bit coordinate typedef in shared package vga_pkg, reused by the sprite renderers.
REQ-030 SHALL use one sub-module, sync_delay (parameterised-depth shift register), instantiated for hs and vs.

Verification
REQ-031 SHALL verify: reset, then 800 cycles -> DrawX returns 0 and DrawY=1; hs low for exactly 96 cycles starting at DrawX=657 (SYNC_DLY=1).
REQ-032 SHALL verify: a full frame of 420000 cycles -> exactly one frame_start; vs low for 1600 cycles; blank high for 307200 cycles.
REQ-033 SHALL verify: tempo_frames=4 for 12 frames -> beat_tick on frames 4, 8 and 12 only, each time coincident with frame_start.
REQ-034 SHALL verify: tempo_frames=0 -> beat_tick on every frame; changing it from 10 to 2 at count 5 -> tick at the next frame_start.
REQ-035 SHALL verify: reset_n pulsed low at DrawX=700, DrawY=300 -> outputs go to reset values asynchronously, hs=1; the first cycle after release gives DrawX=0, DrawY=0, frame_start=1.
REQ-036 SHALL verify: SYNC_DLY=0 vs 2 -> the hs falling edge aligns with DrawX=656 vs 658.
